alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Parameter: ACC_EN, 1, 1 = accumulator logic present; 0 = acc_sel/acc_wr ignored and acc tied to 0.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  request present on a, b, op, cin, acc_sel, acc_wr.
REQ-006 Port: in_ready  output  1  stage 1 can accept a request this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B (ignored when acc_sel=1).
REQ-009 Port: op  input  2  operation: 00 ADD, 01 SUB, 10 OR, 11 AND.
REQ-010 Port: cin  input  1  carry-in for ADD only; ignored for SUB (forced 1), OR, AND.
REQ-011 Port: acc_sel  input  1  use accumulator as operand B.
REQ-012 Port: acc_wr  input  1  write result into accumulator.
REQ-013 Port: out_valid  output  1  result registered and presented.
REQ-014 Port: out_ready  input  1  consumer accepts result.
REQ-015 Port: result  output  WIDTH  operation result.
REQ-016 Port: flags  output  4  {N, Z, V, C}.
REQ-017 Port: acc  output  WIDTH  current accumulator value.

Function
REQ-018 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-019 Two register stages: S1 holds captured request; S2 holds computed result and flags; compute is combinational between S1 and S2.
REQ-020 S1->S2 advance when S1 valid and (S2 empty or out_ready); in_ready = !S1_valid || advance (full throughput, one result per cycle when unstalled).
REQ-021 Latency: accepted request appears on result/out_valid exactly 2 cycles after acceptance when out_ready held high.
REQ-022 out_valid deasserted only by transfer out; result/flags held stable while out_valid && !out_ready.
REQ-023 Results leave in acceptance order; no request dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 ADD: {C, result} = a + B + cin, WIDTH+1-bit sum.
REQ-025 SUB: result = a + ~B + 1; C = NOT raw carry (C=1 means borrow, a < B unsigned).
REQ-026 OR/AND: bitwise; C=0, V=0.
REQ-027 V (ADD/SUB only) = signed overflow: operand sign bits (B inverted for SUB) equal and result sign differs.
REQ-028 N = result[WIDTH-1]; Z = (result == 0), all ops.
REQ-029 When acc_sel=1, B = accumulator value at the S1->S2 advance edge, not at acceptance.
REQ-030 When acc_wr=1, accumulator loads the result on the same edge that S1->S2 advances; back-to-back accumulate requests see each preceding write.
REQ-031 Accumulator and S2 stall together; a stalled S1 does not read or write the accumulator.

Reset
REQ-032 rst_n low asynchronously clears: S1_valid, S2_valid, out_valid=0; result=0; flags=0; acc=0.
REQ-033 in_ready = 1 during and after reset; in-flight requests at reset are discarded, not completed.
REQ-034 Reset deassertion takes effect at first rising clk edge after release; no transfer on that edge is lost.

Structure
REQ-035 Package alu_pkg holds op encoding constants (OP_ADD, OP_SUB, OP_OR, OP_AND) and flag bit indices (F_N=3, F_Z=2, F_V=1, F_C=0).
REQ-036 One sub-module alu_core: combinational, parametrised by WIDTH, inputs a, b, op, cin, outputs result and flags; alu_pipe holds all state.

Verification
REQ-037 WIDTH=8, out_ready=1: ADD a=FF b=01 cin=0 -> result 00, flags N0 Z1 V0 C1, 2 cycles after acceptance.
REQ-038 SUB a=05 b=07 -> result FE, N1 Z0 V0 C1; ADD a=7F b=01 cin=0 -> result 80, N1 V1 C0.
REQ-039 acc=0, three back-to-back ADD a=05 acc_sel=1 acc_wr=1 -> results 05, 0A, 0F; acc=0F after third.
REQ-040 out_ready=0 for 4 cycles, in_valid continuous with OR a=0F b=F0, AND a=0F b=F0, ADD 01+01 -> in_ready low after 2 accepted; on release results FF, 00 (Z1), 02 in order, none lost.
REQ-041 rst_n pulsed low mid-stream with S1 and S2 full -> out_valid=0, acc=00, flags=0 immediately; next accepted request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the pipelined ALU.
//   OP_*  : 2-bit operation encodings on the op port
//   F_*   : bit positions inside the 4-bit flags word {N, Z, V, C}
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_V = 1;
  localparam int F_C = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational ALU datapath shared by the pipeline.
// Ports:
//   a, b    : WIDTH-bit operands
//   op      : operation select (OP_ADD/OP_SUB/OP_OR/OP_AND)
//   cin     : carry-in, used by ADD only
//   result  : WIDTH-bit result
//   flags   : {N, Z, V, C}
`timescale 1ns/1ps
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import alu_pkg::*;

  logic [WIDTH-1:0] b_add;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             c_bit;
  logic             v_bit;

  // SUB reuses the adder as a + ~b + 1, so the caller's cin never reaches it.
  always_comb begin
    b_add    = b;
    carry_in = cin;
    if (op == OP_SUB) begin
      b_add    = ~b;
      carry_in = 1'b1;
    end
    sum = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, carry_in};
  end

  // C on SUB is reported as borrow, the inverse of the raw adder carry.
  // Overflow compares against the effective (possibly inverted) B sign.
  always_comb begin
    result = '0;
    c_bit  = 1'b0;
    v_bit  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        c_bit  = (op == OP_SUB) ? ~sum[WIDTH] : sum[WIDTH];
        v_bit  = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   result = a | b;
      default: result = a & b;
    endcase
    flags      = '0;
    flags[F_N] = result[WIDTH-1];
    flags[F_Z] = (result == '0);
    flags[F_V] = v_bit;
    flags[F_C] = c_bit;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
// Two-stage valid/ready ALU pipeline with an optional accumulator.
// Stage 1 captures the request, stage 2 holds the computed result and flags.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake for a, b, op, cin, acc_sel, acc_wr
//   out_valid / out_ready: result handshake for result, flags
//   acc                  : current accumulator value (0 when ACC_EN = 0)
`timescale 1ns/1ps
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             acc_sel,
  input  logic             acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);
  import alu_pkg::*;

  localparam bit ACC_ON = (ACC_EN != 0);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s1_cin;
  logic             s1_acc_sel;
  logic             s1_acc_wr;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [3:0]       s2_flags;
  logic [WIDTH-1:0] acc_q;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  // Stage 1 may hand over whenever stage 2 is empty or draining this cycle,
  // and can refill on that same edge, giving one result per cycle.
  assign advance  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || advance;

  // The accumulator is sampled at the advance edge, so a request that
  // follows an accumulating one sees its write.
  assign b_eff = (ACC_ON && s1_acc_sel) ? acc_q : s1_b;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (b_eff),
    .op     (s1_op),
    .cin    (s1_cin),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_cin     <= 1'b0;
      s1_acc_sel <= 1'b0;
      s1_acc_wr  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid   <= 1'b1;
      s1_a       <= a;
      s1_b       <= b;
      s1_op      <= op;
      s1_cin     <= cin;
      s1_acc_sel <= acc_sel;
      s1_acc_wr  <= acc_wr;
    end else if (advance) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2 and the accumulator move only on advance so they stall together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
      acc_q     <= '0;
    end else if (advance) begin
      s2_valid  <= 1'b1;
      s2_result <= core_result;
      s2_flags  <= core_flags;
      if (ACC_ON && s1_acc_wr) begin
        acc_q <= core_result;
      end
    end else if (out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign flags     = s2_flags;
  assign acc       = ACC_ON ? acc_q : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
// Directed self-checking bench for alu_pipe at WIDTH=8 with the accumulator.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       cin;
  logic       acc_sel;
  logic       acc_wr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic [7:0] acc;

  int test_count = 0;
  int fail_count = 0;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ORR = 2'b10;
  localparam logic [1:0] ANDD = 2'b11;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .acc_sel   (acc_sel),
    .acc_wr    (acc_wr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .acc       (acc)
  );

  // Present one request; it stays on the bus until changed or dropped.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                               input logic [1:0] top, input logic tcin,
                               input logic tsel, input logic twr);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    op       = top;
    cin      = tcin;
    acc_sel  = tsel;
    acc_wr   = twr;
  endtask

  task automatic dropValid();
    in_valid = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid,
                             input logic [7:0] exp_result, input logic [3:0] exp_flags);
    checkVal({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    checkVal({tag, ".result"}, {24'd0, result}, {24'd0, exp_result});
    checkVal({tag, ".flags"}, {28'd0, flags}, {28'd0, exp_flags});
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(8'h00, 8'h00, ADD, 1'b0, 1'b0, 1'b0);
    dropValid();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 8'h00, 4'b0000);
    checkVal("reset.in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset.acc", {24'd0, acc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD FF+01: wraps to 00 with carry, visible two cycles after acceptance
    applyStimulus(8'hFF, 8'h01, ADD, 1'b0, 1'b0, 1'b0);
    checkVal("add_wrap.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    dropValid();
    checkVal("add_wrap.lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("add_wrap", 1'b1, 8'h00, 4'b0101);

    // Back-to-back SUB (cin must be ignored) and signed-overflow ADD
    applyStimulus(8'h05, 8'h07, SUB, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(8'h7F, 8'h01, ADD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    dropValid();
    checkOutput("sub_borrow", 1'b1, 8'hFE, 4'b1001);
    @(negedge clk);
    checkOutput("add_ovf", 1'b1, 8'h80, 4'b1010);

    // Three back-to-back accumulate requests; b must be ignored
    applyStimulus(8'h05, 8'hAA, ADD, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(8'h05, 8'hAA, ADD, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(8'h05, 8'hAA, ADD, 1'b0, 1'b1, 1'b1);
    checkOutput("acc1", 1'b1, 8'h05, 4'b0000);
    checkVal("acc1.acc", {24'd0, acc}, 32'h05);
    @(negedge clk);
    dropValid();
    checkOutput("acc2", 1'b1, 8'h0A, 4'b0000);
    checkVal("acc2.acc", {24'd0, acc}, 32'h0A);
    @(negedge clk);
    checkOutput("acc3", 1'b1, 8'h0F, 4'b0000);
    checkVal("acc3.acc", {24'd0, acc}, 32'h0F);
    @(negedge clk);
    checkVal("drain.valid", {31'd0, out_valid}, 32'd0);

    // Output stall for four edges with continuous input
    out_ready = 1'b0;
    applyStimulus(8'h0F, 8'hF0, ORR, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("stall.ready1", {31'd0, in_ready}, 32'd1);
    applyStimulus(8'h0F, 8'hF0, ANDD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("stall.ready2", {31'd0, in_ready}, 32'd0);
    applyStimulus(8'h01, 8'h01, ADD, 1'b0, 1'b0, 1'b0);
    checkOutput("stall.or", 1'b1, 8'hFF, 4'b1000);
    @(negedge clk);
    checkVal("stall.ready3", {31'd0, in_ready}, 32'd0);
    checkOutput("stall.hold", 1'b1, 8'hFF, 4'b1000);
    @(negedge clk);
    checkOutput("stall.hold2", 1'b1, 8'hFF, 4'b1000);
    out_ready = 1'b1;
    #1;
    checkVal("release.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    dropValid();
    checkOutput("release.and", 1'b1, 8'h00, 4'b0100);
    @(negedge clk);
    checkOutput("release.add", 1'b1, 8'h02, 4'b0000);
    checkVal("release.acc", {24'd0, acc}, 32'h0F);
    @(negedge clk);
    checkVal("release.empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    applyStimulus(8'h10, 8'h20, ADD, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(8'h30, 8'h10, SUB, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    dropValid();
    checkVal("full.in_ready", {31'd0, in_ready}, 32'd0);
    checkVal("full.acc", {24'd0, acc}, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 1'b0, 8'h00, 4'b0000);
    checkVal("async_rst.acc", {24'd0, acc}, 32'd0);
    checkVal("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(8'h03, 8'h04, ADD, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dropValid();
    checkVal("post_rst.lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("post_rst", 1'b1, 8'h08, 4'b0000);
    @(negedge clk);
    checkVal("post_rst.empty", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
